// File: rtl/seq_detector_param_pkg.sv
// Shared definitions for the parametrised serial pattern detector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding, match-pulse levels, fill-counter width helper.

`ifndef SEQ_DETECTOR_PARAM_DEFS
`define SEQ_DETECTOR_PARAM_DEFS
`define SEQ_FOUND    1'b1
`define SEQ_NOTFOUND 1'b0
`endif

package seq_detector_param_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FILL   = 2'b01,
    DETECT = 2'b10
  } state_e;

  localparam logic FOUND    = `SEQ_FOUND;
  localparam logic NOTFOUND = `SEQ_NOTFOUND;

  // Bits needed to count 0..n accepted bits inclusive.
  function automatic int fill_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Bundle of detector stimulus and result signals.
// Latency: n/a (wiring only).
// Backpressure: none; x is qualified by x_valid and always accepted.
// master drives x/x_valid/pat_in/pat_load/count_clr; slave drives y/match_count/state.

interface seq_detector_param_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) ();
  logic             x;
  logic             x_valid;
  logic [N-1:0]     pat_in;
  logic             pat_load;
  logic             count_clr;
  logic             y;
  logic [CNT_W-1:0] match_count;
  logic [1:0]       state;

  modport master (
    output x, x_valid, pat_in, pat_load, count_clr,
    input  y, match_count, state
  );

  modport slave (
    input  x, x_valid, pat_in, pat_load, count_clr,
    output y, match_count, state
  );
endinterface

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
// Latency: 1 cycle from inc/clr to q.
// Backpressure: none; increments beyond all-ones are dropped.
// Ports: clk, reset (async active-high), clr, inc, q[W-1:0].

module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Serial N-bit pattern detector with run-time pattern load and saturating match count.
// Latency: y pulses the cycle after the edge that accepted the final pattern bit.
// Backpressure: none; every x_valid bit is consumed (pat_load discards a coincident bit).
// Ports: clk, reset (async active-high), bus (slave modport: x, x_valid, pat_in,
//        pat_load, count_clr in; y, match_count, state out).

module seq_detector_param
  import seq_detector_param_pkg::*;
#(
  parameter int N       = 4,
  parameter int CNT_W   = 8,
  parameter int OVERLAP = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_detector_param_if.slave  bus
);

  localparam int             FW        = fill_width(N);
  localparam logic [FW-1:0]  FILL_FULL = FW'(N);

  state_e          state_q, state_d;
  logic [N-1:0]    pat_q, pat_d;
  logic [N-1:0]    hist_q, hist_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic            y_q, y_d;
  logic            cnt_inc;
  logic            load_clr;

  // Candidate values if the current bit is accepted.
  logic [N-1:0]    hist_sh;
  logic [FW-1:0]   fill_nx;
  logic            match;

  assign hist_sh = {hist_q[N-2:0], bus.x};
  assign fill_nx = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FW'(1);
  assign match   = (hist_sh == pat_q) && (fill_nx == FILL_FULL);

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    y_d      = NOTFOUND;
    cnt_inc  = 1'b0;
    load_clr = 1'b0;

    case (state_q)
      IDLE, FILL, DETECT: begin
        if (bus.pat_load) begin
          // Load restarts detection from any legal state; a coincident bit is dropped.
          state_d  = FILL;
          pat_d    = bus.pat_in;
          hist_d   = '0;
          fill_d   = '0;
          load_clr = 1'b1;
        end else if (bus.x_valid && (state_q != IDLE)) begin
          hist_d = hist_sh;
          fill_d = fill_nx;
          if (fill_nx == FILL_FULL) begin
            state_d = DETECT;
          end
          if (match) begin
            y_d     = FOUND;
            cnt_inc = 1'b1;
            if (OVERLAP == 0) begin
              // Non-overlapping: next match must be built from N fresh bits.
              hist_d  = '0;
              fill_d  = '0;
              state_d = FILL;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pattern, history and fill registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q  <= '0;
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  // Registered match pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q <= NOTFOUND;
    end else begin
      y_q <= y_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.count_clr | load_clr),
    .inc   (cnt_inc),
    .q     (bus.match_count)
  );

  assign bus.y     = y_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: three detector builds (overlap / non-overlap / 2-bit counter)
// share one stimulus stream; a queue-based reference model predicts their outputs.

module tb_seq_detector_param;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         x, xv, pl, cc;
  logic [N-1:0] pin;

  seq_detector_param_if #(.N(N), .CNT_W(8)) bus0 ();
  seq_detector_param_if #(.N(N), .CNT_W(8)) bus1 ();
  seq_detector_param_if #(.N(N), .CNT_W(2)) bus2 ();

  assign bus0.x = x;  assign bus0.x_valid = xv; assign bus0.pat_in = pin;
  assign bus0.pat_load = pl; assign bus0.count_clr = cc;
  assign bus1.x = x;  assign bus1.x_valid = xv; assign bus1.pat_in = pin;
  assign bus1.pat_load = pl; assign bus1.count_clr = cc;
  assign bus2.x = x;  assign bus2.x_valid = xv; assign bus2.pat_in = pin;
  assign bus2.pat_load = pl; assign bus2.count_clr = cc;

  seq_detector_param #(.N(N), .CNT_W(8), .OVERLAP(1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  seq_detector_param #(.N(N), .CNT_W(8), .OVERLAP(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  seq_detector_param #(.N(N), .CNT_W(2), .OVERLAP(1)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  always #5 clk = ~clk;

  typedef struct {
    bit y;
    int cnt;
    int st;
  } exp_t;

  exp_t         sbq [3][$];
  bit           bq  [3][$];   // accepted bits since last load/flush, oldest first
  bit           loaded [3];
  int           cnt [3];
  logic [N-1:0] mpat;
  int           ovl  [3] = '{1, 0, 1};
  int           cmax [3] = '{255, 255, 3};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d at t=%0t", name, got, exp, $time);
  endtask

  function automatic int dut_y(input int d);
    case (d)
      0: return int'(bus0.y);
      1: return int'(bus1.y);
      default: return int'(bus2.y);
    endcase
  endfunction

  function automatic int dut_cnt(input int d);
    case (d)
      0: return int'(bus0.match_count);
      1: return int'(bus1.match_count);
      default: return int'(bus2.match_count);
    endcase
  endfunction

  function automatic int dut_st(input int d);
    case (d)
      0: return int'(bus0.state);
      1: return int'(bus1.state);
      default: return int'(bus2.state);
    endcase
  endfunction

  function automatic bit window_matches(input int d);
    for (int i = 0; i < N; i++) begin
      if (bq[d][i] != mpat[N-1-i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      loaded[d] = 1'b0;
      cnt[d]    = 0;
      bq[d].delete();
    end
    mpat = '0;
  endtask

  // Predict the outputs seen after the coming clock edge, from the driven inputs.
  task automatic model_step();
    if (pl) mpat = pin;
    for (int d = 0; d < 3; d++) begin
      exp_t e;
      e.y = 1'b0;
      if (pl) begin
        loaded[d] = 1'b1;
        cnt[d]    = 0;
        bq[d].delete();
      end else if (loaded[d] && xv) begin
        bq[d].push_back(x);
        if (bq[d].size() > N) void'(bq[d].pop_front());
        if (bq[d].size() == N && window_matches(d)) begin
          e.y = 1'b1;
          if (cnt[d] < cmax[d]) cnt[d]++;
          if (ovl[d] == 0) bq[d].delete();
        end
      end
      if (cc) cnt[d] = 0;
      e.cnt = cnt[d];
      e.st  = !loaded[d] ? 0 : (bq[d].size() == N ? 2 : 1);
      sbq[d].push_back(e);
    end
  endtask

  task automatic apply(input bit bx, input bit bv, input bit bl, input logic [N-1:0] bp, input bit bc);
    @(posedge clk);
    #2;
    x = bx; xv = bv; pl = bl; pin = bp; cc = bc;
    model_step();
  endtask

  task automatic send(input logic [31:0] s, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      apply(s[i], 1'b1, 1'b0, '0, 1'b0);
      for (int g = 0; g < gap; g++) apply(1'($urandom_range(0, 1)), 1'b0, 1'b0, '0, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1'($urandom_range(0, 1)), 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_y[%0d]", tag, d), dut_y(d), 0);
      check($sformatf("%s_count[%0d]", tag, d), dut_cnt(d), 0);
      check($sformatf("%s_state[%0d]", tag, d), dut_st(d), 0);
    end
  endtask

  // Reset between edges; outputs must clear before any further clock edge.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #4;
    reset = 1'b1;
    xv = 1'b0; pl = 1'b0; cc = 1'b0;
    #1;
    check_zero(tag);
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Monitor: compare every predicted output against the DUT just after each edge.
  always begin
    @(posedge clk);
    #1;
    if (!reset) begin
      for (int d = 0; d < 3; d++) begin
        if (sbq[d].size() > 0) begin
          exp_t e;
          e = sbq[d].pop_front();
          check($sformatf("y[%0d]", d), dut_y(d), int'(e.y));
          check($sformatf("count[%0d]", d), dut_cnt(d), e.cnt);
          check($sformatf("state[%0d]", d), dut_st(d), e.st);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    x = 1'b0; xv = 1'b0; pl = 1'b0; cc = 1'b0; pin = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(posedge clk);
    #2;
    reset = 1'b0;

    // Basic detection and overlap behaviour.
    apply(1'b0, 1'b0, 1'b1, 4'b0101, 1'b0);
    send(32'b01010101, 8, 0);
    idle(2);

    // Gaps with x_valid low between bits.
    apply(1'b0, 1'b0, 1'b1, 4'b0101, 1'b0);
    send(32'b0101, 4, 3);
    idle(2);

    // Saturation of the 2-bit counter, then count_clr coincident with a match.
    apply(1'b0, 1'b0, 1'b1, 4'b0101, 1'b0);
    send(32'b0101010101010, 13, 0);
    apply(1'b1, 1'b1, 1'b0, '0, 1'b1);
    idle(2);

    // Reload mid-stream discards the coincident bit.
    apply(1'b0, 1'b0, 1'b1, 4'b0101, 1'b0);
    send(32'b010, 3, 0);
    apply(1'b1, 1'b1, 1'b1, 4'b0101, 1'b0);
    send(32'b0101, 4, 0);
    idle(1);

    // Async reset while detecting, then data with no pattern loaded.
    apply(1'b0, 1'b0, 1'b1, 4'b0110, 1'b0);
    send(32'b011001, 6, 0);
    async_reset("midreset");
    send(32'b01100110, 8, 0);
    idle(1);

    // Randomised traffic.
    for (int it = 0; it < 3000; it++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 3) begin
        async_reset("rndreset");
      end else if (!loaded[0] || r < 15) begin
        apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
              N'($urandom_range(0, (1 << N) - 1)), 1'($urandom_range(0, 9) == 0));
      end else begin
        apply(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7), 1'b0, '0,
              ($urandom_range(0, 99) < 3));
      end
    end
    idle(1);

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 20; k++) begin
      if (sbq[0].size() == 0 && sbq[1].size() == 0 && sbq[2].size() == 0) break;
      @(posedge clk);
      #2;
    end
    for (int d = 0; d < 3; d++) check($sformatf("drain[%0d]", d), sbq[d].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
